set_bit_streamer: RTL and testbench
===================================

SET_BIT_STREAMER -- requirements
Module: set_bit_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 12, the input vector width (>=2).
REQ-002 SHALL have localparam IDX_W, value $clog2(WIDTH), the index width.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port vec_valid_i  input  1  upstream vector valid.
REQ-006 SHALL have port vec_i  input  WIDTH  vector whose set bits are streamed.
REQ-007 SHALL have port vec_ready_o  output  1  block can accept vec_i this cycle.
REQ-008 SHALL have port bit_valid_o  output  1  output beat valid.
REQ-009 SHALL have port bit_onehot_o  output  WIDTH  one-hot isolate of the current lowest remaining set bit.
REQ-010 SHALL have port bit_idx_o  output  IDX_W  binary index of bit_onehot_o.
REQ-011 SHALL have port bit_last_o  output  1  current beat is the highest set bit of the vector.
REQ-012 SHALL have port bit_ready_i  input  1  downstream accepts beat.

Function
REQ-013 SHALL implement two states: IDLE and STREAM, with remaining-vector register rem_q[WIDTH].
REQ-014 SHALL drive vec_ready_o=1 in IDLE, and in STREAM only when bit_valid_o & bit_last_o & bit_ready_i; else 0.
REQ-015 SHALL perform a vector handshake when vec_valid_i & vec_ready_o: rem_q <= vec_i.
REQ-016 SHALL transition to STREAM on a handshake with nonzero vec_i; with vec_i==0, SHALL remain in or return to IDLE and emit no beat.
REQ-017 SHALL assert bit_valid_o exactly when in STREAM; first beat valid the cycle after the accepting edge (latency 1).
REQ-018 SHALL drive bit_onehot_o = rem_q & (~rem_q + 1), modulo 2^WIDTH, in STREAM.
REQ-019 SHALL drive bit_idx_o = position of the single set bit of bit_onehot_o.
REQ-020 SHALL drive bit_last_o = 1 iff (rem_q & ~bit_onehot_o)==0, in STREAM.
REQ-021 SHALL drive bit_onehot_o, bit_idx_o, bit_last_o to 0 in IDLE.
REQ-022 SHALL, on beat handshake (bit_valid_o & bit_ready_i), not last: clear the lowest set bit of rem_q and stay in STREAM.
REQ-023 SHALL, on last-beat handshake without a new vector, go to IDLE with rem_q <= 0.
REQ-024 SHALL, on last-beat handshake coinciding with a vector handshake, load the new vector per REQ-015/016 with no bubble cycle.
REQ-025 SHALL hold all outputs stable while bit_valid_o & ~bit_ready_i; vec_i is ignored in STREAM unless REQ-014 permits acceptance.
REQ-026 SHALL emit beats in strictly ascending index order, one per handshake, count equal to popcount of the accepted vector.

Reset
REQ-027 SHALL, on rst_ni low, asynchronously force IDLE, rem_q=0, bit_valid_o=0, bit_onehot_o=0, bit_idx_o=0, bit_last_o=0, vec_ready_o=1 (and cnt_o=0 when present).
REQ-028 SHALL abandon any in-progress vector on mid-stream reset; no further beats of it after release.

Configuration
REQ-029 SHALL, with macro SET_BIT_STREAMER_CNT_EN defined, add port cnt_o  output  $clog2(WIDTH+1)  set bits remaining including current beat.
REQ-030 SHALL, with the macro defined, load cnt_o with popcount(vec_i) on vector handshake, decrement on each beat handshake, and read 0 in IDLE.
REQ-031 SHALL, without the macro, omit cnt_o and its counter; all other behaviour identical.

Verification
REQ-032 SHALL cover: vec_i=12'h0A4, bit_ready_i=1 -> 3 consecutive beats idx 2,5,7, onehot 12'h004,12'h020,12'h080, bit_last_o on idx 7 only.
REQ-033 SHALL cover: vec_i=12'h0A4, bit_ready_i low 3 cycles after first valid -> idx 2/onehot 12'h004 held stable 4 cycles, then 5,7.
REQ-034 SHALL cover: vec_i=12'h000 accepted -> no bit_valid_o, vec_ready_o stays 1, state IDLE.
REQ-035 SHALL cover: 12'h801 then 12'h002 offered continuously, bit_ready_i=1 -> beats idx 0, 11(last), 1(last) in 3 consecutive cycles.
REQ-036 SHALL cover: 12'hFFF, rst_ni low after first beat -> outputs 0 immediately, vec_ready_o=1, no idx 1 beat after release.
REQ-037 SHALL cover, macro defined: 12'hFFF, bit_ready_i=1 -> cnt_o 12,11,...,1 on successive beats, then 0 in IDLE.

Source files
------------

// File: rtl/set_bit_streamer.sv
// Streams the set bits of an accepted vector, lowest index first, one beat per handshake.
// Optional remaining-bit counter port cnt_o is enabled by defining SET_BIT_STREAMER_CNT_EN.
module set_bit_streamer #(
   parameter  int WIDTH = 12,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             vec_valid_i,
   input  logic [WIDTH-1:0] vec_i,
   output logic             vec_ready_o,
   output logic             bit_valid_o,
   output logic [WIDTH-1:0] bit_onehot_o,
   output logic [IDX_W-1:0] bit_idx_o,
   output logic             bit_last_o,
   input  logic             bit_ready_i
`ifdef SET_BIT_STREAMER_CNT_EN
   ,
   output logic [$clog2(WIDTH+1)-1:0] cnt_o
`endif
);

   localparam logic IDLE   = 1'b0;
   localparam logic STREAM = 1'b1;

   logic             state_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] onehot;
   logic [WIDTH-1:0] rest;
   logic [IDX_W-1:0] idx;
   logic             streaming;
   logic             last;
   logic             vec_hs;
   logic             beat_hs;

   assign streaming = (state_q == STREAM);
   assign onehot    = streaming ? (rem_q & (~rem_q + WIDTH'(1))) : '0;
   assign rest      = rem_q & ~onehot;
   assign last      = streaming & (rest == '0);

   assign bit_valid_o  = streaming;
   assign bit_onehot_o = onehot;
   assign bit_idx_o    = idx;
   assign bit_last_o   = last;
   assign vec_ready_o  = ~streaming | (last & bit_ready_i);

   assign vec_hs  = vec_valid_i & vec_ready_o;
   assign beat_hs = streaming & bit_ready_i;

   // binary encode the isolated one-hot bit (zero when idle)
   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (onehot[i]) idx = IDX_W'(i);
      end
   end

   // load on vector handshake, otherwise peel off the lowest bit per beat
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rem_q   <= '0;
      end else if (vec_hs) begin
         rem_q   <= vec_i;
         state_q <= (vec_i != '0) ? STREAM : IDLE;
      end else if (beat_hs) begin
         if (last) begin
            rem_q   <= '0;
            state_q <= IDLE;
         end else begin
            rem_q   <= rest;
         end
      end
   end

`ifdef SET_BIT_STREAMER_CNT_EN
   localparam int CNT_W = $clog2(WIDTH+1);

   logic [CNT_W-1:0] cnt_q;

   function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) n = n + CNT_W'(v[i]);
      return n;
   endfunction

   // remaining set bits, current beat included
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (vec_hs) begin
         cnt_q <= popcnt(vec_i);
      end else if (beat_hs) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign cnt_o = streaming ? cnt_q : '0;
`endif

endmodule

// File: tb/tb_set_bit_streamer.sv
// Directed self-checking bench for set_bit_streamer (WIDTH=12).
// Define SET_BIT_STREAMER_CNT_EN to also check the remaining-bit counter.
module tb_set_bit_streamer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vec_valid = 1'b0;
   logic [11:0] vec = '0;
   logic        vec_ready;
   logic        bit_valid;
   logic [11:0] onehot;
   logic [3:0]  idx;
   logic        last;
   logic        bit_ready = 1'b0;
`ifdef SET_BIT_STREAMER_CNT_EN
   logic [3:0]  cnt;
`endif

   int checks = 0;
   int errors = 0;

   set_bit_streamer #(.WIDTH(12)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .vec_valid_i  (vec_valid),
      .vec_i        (vec),
      .vec_ready_o  (vec_ready),
      .bit_valid_o  (bit_valid),
      .bit_onehot_o (onehot),
      .bit_idx_o    (idx),
      .bit_last_o   (last),
      .bit_ready_i  (bit_ready)
`ifdef SET_BIT_STREAMER_CNT_EN
      ,
      .cnt_o        (cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (bit_valid !== 1'b0) begin
         errors++; $display("FAIL rst_valid got %b want 0", bit_valid);
      end
      checks++;
      if (onehot !== 12'h000 || idx !== 4'd0 || last !== 1'b0) begin
         errors++;
         $display("FAIL rst_beat got oh=%h idx=%0d last=%b want 0/0/0", onehot, idx, last);
      end
      checks++;
      if (vec_ready !== 1'b1) begin
         errors++; $display("FAIL rst_ready got %b want 1", vec_ready);
      end
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [3:0]  e_idx [3];
      logic [11:0] e_oh  [3];
      e_idx = '{4'd2, 4'd5, 4'd7};
      e_oh  = '{12'h004, 12'h020, 12'h080};
      step();
      vec_valid = 1'b1; vec = 12'h0A4; bit_ready = 1'b1;
      #1;
      checks++;
      if (vec_ready !== 1'b1) begin
         errors++; $display("FAIL basic_ready_idle got %b want 1", vec_ready);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         vec_valid = 1'b0;
         #1;
         checks++;
         if (bit_valid !== 1'b1 || idx !== e_idx[k] || onehot !== e_oh[k]
             || last !== (k == 2)) begin
            errors++;
            $display("FAIL basic_beat%0d got v=%b idx=%0d oh=%h last=%b want 1/%0d/%h/%b",
                     k, bit_valid, idx, onehot, last, e_idx[k], e_oh[k], k == 2);
         end
      end
      step();
      #1;
      checks++;
      if (bit_valid !== 1'b0 || vec_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_idle got v=%b rdy=%b want 0/1", bit_valid, vec_ready);
      end
   endtask

   task automatic test_stall();
      step();
      vec_valid = 1'b1; vec = 12'h0A4; bit_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         vec_valid = (k < 3); vec = 12'hFFF;
         bit_ready = (k == 3);
         #1;
         checks++;
         if (bit_valid !== 1'b1 || idx !== 4'd2 || onehot !== 12'h004 || last !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d got v=%b idx=%0d oh=%h last=%b want 1/2/004/0",
                     k, bit_valid, idx, onehot, last);
         end
         checks++;
         if (vec_ready !== 1'b0) begin
            errors++; $display("FAIL stall_ready%0d got %b want 0", k, vec_ready);
         end
      end
      step();
      #1;
      checks++;
      if (bit_valid !== 1'b1 || idx !== 4'd5 || last !== 1'b0) begin
         errors++;
         $display("FAIL stall_beat1 got v=%b idx=%0d last=%b want 1/5/0", bit_valid, idx, last);
      end
      step();
      #1;
      checks++;
      if (bit_valid !== 1'b1 || idx !== 4'd7 || last !== 1'b1) begin
         errors++;
         $display("FAIL stall_beat2 got v=%b idx=%0d last=%b want 1/7/1", bit_valid, idx, last);
      end
      step();
      #1;
      checks++;
      if (bit_valid !== 1'b0) begin
         errors++; $display("FAIL stall_idle got %b want 0", bit_valid);
      end
   endtask

   task automatic test_zero();
      step();
      vec_valid = 1'b1; vec = 12'h000; bit_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         vec_valid = 1'b0;
         #1;
         checks++;
         if (bit_valid !== 1'b0 || vec_ready !== 1'b1 || onehot !== 12'h000) begin
            errors++;
            $display("FAIL zero_c%0d got v=%b rdy=%b oh=%h want 0/1/000",
                     k, bit_valid, vec_ready, onehot);
         end
      end
   endtask

   task automatic test_back_to_back();
      step();
      vec_valid = 1'b1; vec = 12'h801; bit_ready = 1'b1;
      step();
      vec = 12'h002;
      #1;
      checks++;
      if (bit_valid !== 1'b1 || idx !== 4'd0 || last !== 1'b0 || vec_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_beat0 got v=%b idx=%0d last=%b rdy=%b want 1/0/0/0",
                  bit_valid, idx, last, vec_ready);
      end
      step();
      #1;
      checks++;
      if (bit_valid !== 1'b1 || idx !== 4'd11 || last !== 1'b1 || vec_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_beat1 got v=%b idx=%0d last=%b rdy=%b want 1/11/1/1",
                  bit_valid, idx, last, vec_ready);
      end
      step();
      vec_valid = 1'b0;
      #1;
      checks++;
      if (bit_valid !== 1'b1 || idx !== 4'd1 || onehot !== 12'h002 || last !== 1'b1) begin
         errors++;
         $display("FAIL b2b_beat2 got v=%b idx=%0d oh=%h last=%b want 1/1/002/1",
                  bit_valid, idx, onehot, last);
      end
      step();
      #1;
      checks++;
      if (bit_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_idle got %b want 0", bit_valid);
      end
   endtask

   task automatic test_full();
      step();
      vec_valid = 1'b1; vec = 12'hFFF; bit_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         vec_valid = 1'b0;
         #1;
         checks++;
         if (bit_valid !== 1'b1 || idx !== 4'(k) || onehot !== (12'd1 << k)
             || last !== (k == 11)) begin
            errors++;
            $display("FAIL full_beat%0d got v=%b idx=%0d oh=%h last=%b want 1/%0d/%h/%b",
                     k, bit_valid, idx, onehot, last, k, 12'd1 << k, k == 11);
         end
`ifdef SET_BIT_STREAMER_CNT_EN
         checks++;
         if (cnt !== 4'(12 - k)) begin
            errors++; $display("FAIL full_cnt%0d got %0d want %0d", k, cnt, 12 - k);
         end
`endif
      end
      step();
      #1;
      checks++;
      if (bit_valid !== 1'b0 || vec_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_idle got v=%b rdy=%b want 0/1", bit_valid, vec_ready);
      end
`ifdef SET_BIT_STREAMER_CNT_EN
      checks++;
      if (cnt !== 4'd0) begin
         errors++; $display("FAIL full_cnt_idle got %0d want 0", cnt);
      end
`endif
   endtask

   task automatic test_mid_reset();
      step();
      vec_valid = 1'b1; vec = 12'hFFF; bit_ready = 1'b1;
      step();
      vec_valid = 1'b0;
      #1;
      checks++;
      if (bit_valid !== 1'b1 || idx !== 4'd0) begin
         errors++;
         $display("FAIL mrst_beat0 got v=%b idx=%0d want 1/0", bit_valid, idx);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bit_valid !== 1'b0 || onehot !== 12'h000 || idx !== 4'd0
          || last !== 1'b0 || vec_ready !== 1'b1) begin
         errors++;
         $display("FAIL mrst_async got v=%b oh=%h idx=%0d last=%b rdy=%b want 0/000/0/0/1",
                  bit_valid, onehot, idx, last, vec_ready);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         #1;
         checks++;
         if (bit_valid !== 1'b0 || idx !== 4'd0) begin
            errors++;
            $display("FAIL mrst_after%0d got v=%b idx=%0d want 0/0", k, bit_valid, idx);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero();
      test_back_to_back();
      test_full();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
